// File: rtl/fpu_pipe_pkg.sv
// Shared types and helpers for the float result pipeline: op-kind encoding,
// per-stage control entry and the kind-to-latency lookup.
package fpu_pipe_pkg;

    localparam int unsigned KIND_W = 2;

    typedef enum logic [KIND_W-1:0] {
        KIND_CVT  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_ADSB = 2'd2,
        KIND_MUL  = 2'd3
    } kind_e;

    // Control half of a stage entry; rd and data are sized by the instantiating module.
    typedef struct packed {
        logic  valid;
        logic  we;
        kind_e kind;
    } stage_ctrl_t;

    // Stage at which a unit's result appears, for the configured latencies.
    function automatic int unsigned kind_lat(
        input kind_e       kind,
        input int unsigned lat_cvt,
        input int unsigned lat_load,
        input int unsigned lat_adsb,
        input int unsigned lat_mul
    );
        int unsigned lat;
        lat = lat_cvt;
        case (kind)
            KIND_CVT:  lat = lat_cvt;
            KIND_LOAD: lat = lat_load;
            KIND_ADSB: lat = lat_adsb;
            KIND_MUL:  lat = lat_mul;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpu_pipe_stage.sv
// One result-pipeline stage: holds the entry and merges the unit result
// into the outgoing data when this stage is the op's result latency.
module fpu_pipe_stage
    import fpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RAG_AW   = 5,
    parameter int unsigned STAGE    = 1,
    parameter int unsigned LAT_CVT  = 1,
    parameter int unsigned LAT_LOAD = 2,
    parameter int unsigned LAT_ADSB = 3,
    parameter int unsigned LAT_MUL  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  stage_ctrl_t       in_ctrl,
    input  logic [RAG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] cvt_data,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] adsb_data,
    input  logic [DATA_W-1:0] mul_data,
    output stage_ctrl_t       ctrl,
    output logic [RAG_AW-1:0] rd,
    output logic [DATA_W-1:0] eff_c
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] unit_c;

    // Stage register; reset discards whatever op was in flight here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl   <= '0;
            rd     <= '0;
            data_q <= '0;
        end else begin
            ctrl   <= in_ctrl;
            rd     <= in_rd;
            data_q <= in_data;
        end
    end

    // Effective data: live unit output at the op's latency, stored data otherwise.
    always_comb begin
        unit_c = cvt_data;
        case (ctrl.kind)
            KIND_CVT:  unit_c = cvt_data;
            KIND_LOAD: unit_c = load_data;
            KIND_ADSB: unit_c = adsb_data;
            KIND_MUL:  unit_c = mul_data;
        endcase
        eff_c = (kind_lat(ctrl.kind, LAT_CVT, LAT_LOAD, LAT_ADSB, LAT_MUL) == STAGE)
              ? unit_c : data_q;
    end

endmodule

// File: rtl/fpu_result_pipe.sv
// Float writeback pipeline: tracks issued ops through DEPTH stages, merges unit
// results at their latencies, writes back in order at stage DEPTH and raises a
// RAW issue stall. Optional result forwarding: define FPU_RESULT_FWD_EN.
module fpu_result_pipe
    import fpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RAG_AW   = 5,
    parameter int unsigned DEPTH    = 5,
    parameter int unsigned LAT_CVT  = 1,
    parameter int unsigned LAT_LOAD = 2,
    parameter int unsigned LAT_ADSB = 3,
    parameter int unsigned LAT_MUL  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [1:0]        issue_kind,
    input  logic [RAG_AW-1:0] issue_rd,
    input  logic [RAG_AW-1:0] rs1_addr,
    input  logic [RAG_AW-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    output logic              issue_stall,
    input  logic [DATA_W-1:0] cvt_data,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] adsb_data,
    input  logic [DATA_W-1:0] mul_data,
    output logic              wb_en,
    output logic [RAG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd1_en,
    output logic              fwd2_en,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
);

    // Parameter legality, rejected at elaboration.
    if (DEPTH < 2) begin : g_bad_depth
        $error("fpu_result_pipe: DEPTH must be >= 2");
    end
    if (LAT_CVT < 1 || LAT_CVT > DEPTH) begin : g_bad_cvt
        $error("fpu_result_pipe: LAT_CVT out of 1..DEPTH");
    end
    if (LAT_LOAD < 1 || LAT_LOAD > DEPTH) begin : g_bad_load
        $error("fpu_result_pipe: LAT_LOAD out of 1..DEPTH");
    end
    if (LAT_ADSB < 1 || LAT_ADSB > DEPTH) begin : g_bad_adsb
        $error("fpu_result_pipe: LAT_ADSB out of 1..DEPTH");
    end
    if (LAT_MUL < 1 || LAT_MUL > DEPTH) begin : g_bad_mul
        $error("fpu_result_pipe: LAT_MUL out of 1..DEPTH");
    end

    stage_ctrl_t       ctrl [1:DEPTH];
    logic [RAG_AW-1:0] rd   [1:DEPTH];
    logic [DATA_W-1:0] eff  [1:DEPTH];

    stage_ctrl_t       head_ctrl;
    logic [RAG_AW-1:0] head_rd;
    logic [DEPTH:1]    hit1;
    logic [DEPTH:1]    hit2;
    logic              stall_c;

    // Stage 1 takes the accepted op, otherwise a bubble.
    always_comb begin
        head_ctrl = '0;
        head_rd   = '0;
        if (issue_valid && !stall_c) begin
            head_ctrl.valid = 1'b1;
            head_ctrl.we    = issue_we;
            head_ctrl.kind  = kind_e'(issue_kind);
            head_rd         = issue_rd;
        end
    end

    for (genvar s = 1; s <= DEPTH; s++) begin : g_stage
        stage_ctrl_t       src_ctrl;
        logic [RAG_AW-1:0] src_rd;
        logic [DATA_W-1:0] src_data;

        if (s == 1) begin : g_head
            assign src_ctrl = head_ctrl;
            assign src_rd   = head_rd;
            assign src_data = '0;
        end else begin : g_body
            assign src_ctrl = ctrl[s-1];
            assign src_rd   = rd[s-1];
            assign src_data = eff[s-1];
        end

        fpu_pipe_stage #(
            .DATA_W  (DATA_W),
            .RAG_AW  (RAG_AW),
            .STAGE   (s),
            .LAT_CVT (LAT_CVT),
            .LAT_LOAD(LAT_LOAD),
            .LAT_ADSB(LAT_ADSB),
            .LAT_MUL (LAT_MUL)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_ctrl  (src_ctrl),
            .in_rd    (src_rd),
            .in_data  (src_data),
            .cvt_data (cvt_data),
            .load_data(load_data),
            .adsb_data(adsb_data),
            .mul_data (mul_data),
            .ctrl     (ctrl[s]),
            .rd       (rd[s]),
            .eff_c    (eff[s])
        );
    end

    // Scoreboard: which in-flight writers each source depends on.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int s = 1; s <= DEPTH; s++) begin
            hit1[s] = rs1_used && ctrl[s].valid && ctrl[s].we && (rd[s] == rs1_addr);
            hit2[s] = rs2_used && ctrl[s].valid && ctrl[s].we && (rd[s] == rs2_addr);
        end
    end

`ifdef FPU_RESULT_FWD_EN
    logic [DEPTH:1]    ready;
    logic              ok1;
    logic              ok2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;

    // Youngest matching stage decides: forward if its result exists, else stall.
    always_comb begin
        ready = '0;
        ok1   = 1'b0;
        ok2   = 1'b0;
        val1  = '0;
        val2  = '0;
        for (int s = 1; s <= DEPTH; s++) begin
            ready[s] = kind_lat(ctrl[s].kind, LAT_CVT, LAT_LOAD, LAT_ADSB, LAT_MUL)
                       <= unsigned'(s);
        end
        for (int s = DEPTH; s >= 1; s--) begin
            if (hit1[s]) begin
                ok1  = ready[s];
                val1 = eff[s];
            end
            if (hit2[s]) begin
                ok2  = ready[s];
                val2 = eff[s];
            end
        end
        stall_c   = issue_valid && (((|hit1) && !ok1) || ((|hit2) && !ok2));
        fwd1_en   = issue_valid && (|hit1) && ok1;
        fwd2_en   = issue_valid && (|hit2) && ok2;
        fwd1_data = fwd1_en ? val1 : '0;
        fwd2_data = fwd2_en ? val2 : '0;
    end
`else
    // No forwarding: any pending writer of a used source blocks issue.
    always_comb begin
        stall_c   = issue_valid && ((|hit1) || (|hit2));
        fwd1_en   = 1'b0;
        fwd2_en   = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
    end
`endif

    assign issue_stall = stall_c;

    // In-order register-file write from the last stage.
    assign wb_en   = ctrl[DEPTH].valid && ctrl[DEPTH].we;
    assign wb_rd   = rd[DEPTH];
    assign wb_data = eff[DEPTH];

endmodule

// File: tb/tb_fpu_result_pipe.sv
// Scoreboard bench for fpu_result_pipe: directed scenarios plus random ops,
// checked against an op-level model of issue, hazards and writeback timing.
module tb_fpu_result_pipe;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RAG_AW   = 5;
    localparam int unsigned DEPTH    = 5;
    localparam int unsigned LAT_CVT  = 1;
    localparam int unsigned LAT_LOAD = 2;
    localparam int unsigned LAT_ADSB = 3;
    localparam int unsigned LAT_MUL  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid, issue_we, rs1_used, rs2_used;
    logic [1:0]        issue_kind;
    logic [RAG_AW-1:0] issue_rd, rs1_addr, rs2_addr;
    logic              issue_stall;
    logic [DATA_W-1:0] cvt_data, load_data, adsb_data, mul_data;
    logic              wb_en, fwd1_en, fwd2_en;
    logic [RAG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data, fwd1_data, fwd2_data;

    always #5 clk = ~clk;

    fpu_result_pipe #(
        .DATA_W(DATA_W), .RAG_AW(RAG_AW), .DEPTH(DEPTH),
        .LAT_CVT(LAT_CVT), .LAT_LOAD(LAT_LOAD), .LAT_ADSB(LAT_ADSB), .LAT_MUL(LAT_MUL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_kind(issue_kind),
        .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .issue_stall(issue_stall),
        .cvt_data(cvt_data), .load_data(load_data), .adsb_data(adsb_data), .mul_data(mul_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
    );

    typedef struct {
        int                acc;
        logic              we;
        logic [1:0]        kind;
        logic [RAG_AW-1:0] rd;
        logic [DATA_W-1:0] val;
    } op_t;

    typedef struct {
        int                due;
        logic [RAG_AW-1:0] rd;
        logic [DATA_W-1:0] val;
    } wb_t;

    op_t inflight[$];
    wb_t sb[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    logic in_reset = 1'b1;
    logic exp_stall = 1'b0, exp_f1 = 1'b0, exp_f2 = 1'b0;
    logic [DATA_W-1:0] exp_f1d = '0, exp_f2d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned lat_of(input logic [1:0] k);
        case (k)
            2'd0:    return LAT_CVT;
            2'd1:    return LAT_LOAD;
            2'd2:    return LAT_ADSB;
            default: return LAT_MUL;
        endcase
    endfunction

    // Stage an op occupies in the current cycle (1 right after acceptance).
    function automatic int stage_of(input op_t o);
        return cyc - o.acc + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Retire finished ops and present each unit's result in its latency cycle.
    task automatic drive_units();
        while (inflight.size() > 0 && stage_of(inflight[0]) > int'(DEPTH))
            void'(inflight.pop_front());
        cvt_data  = $urandom;
        load_data = $urandom;
        adsb_data = $urandom;
        mul_data  = $urandom;
        foreach (inflight[i]) begin
            if (stage_of(inflight[i]) == int'(lat_of(inflight[i].kind))) begin
                case (inflight[i].kind)
                    2'd0:    cvt_data  = inflight[i].val;
                    2'd1:    load_data = inflight[i].val;
                    2'd2:    adsb_data = inflight[i].val;
                    default: mul_data  = inflight[i].val;
                endcase
            end
        end
    endtask

    // Hazard model for one source: youngest pending writer decides.
    task automatic src_eval(input logic [RAG_AW-1:0] a, input logic used,
                            output logic st, output logic fe, output logic [DATA_W-1:0] fd);
        int  best = int'(DEPTH) + 1;
        op_t bo;
        st = 1'b0;
        fe = 1'b0;
        fd = '0;
        bo = '{0, 1'b0, 2'd0, '0, '0};
        if (used) begin
            foreach (inflight[i]) begin
                int s = stage_of(inflight[i]);
                if (inflight[i].we && inflight[i].rd == a && s >= 1 && s <= int'(DEPTH) && s < best) begin
                    best = s;
                    bo   = inflight[i];
                end
            end
            if (best <= int'(DEPTH)) begin
`ifdef FPU_RESULT_FWD_EN
                if (int'(lat_of(bo.kind)) <= best) begin
                    fe = 1'b1;
                    fd = bo.val;
                end else begin
                    st = 1'b1;
                end
`else
                st = 1'b1;
`endif
            end
        end
    endtask

    // Present an op (or an idle cycle) and hold it until the model accepts it.
    task automatic issue_op(input logic v, input logic we, input logic [1:0] kind,
                            input logic [RAG_AW-1:0] rdv, input logic [RAG_AW-1:0] r1,
                            input logic [RAG_AW-1:0] r2, input logic u1, input logic u2,
                            input logic [DATA_W-1:0] val);
        int   waited = 0;
        bit   done = 1'b0;
        logic s1, s2, f1, f2;
        logic [DATA_W-1:0] d1, d2;
        while (!done) begin
            @(negedge clk);
            drive_units();
            issue_valid = v;
            issue_we    = we;
            issue_kind  = kind;
            issue_rd    = rdv;
            rs1_addr    = r1;
            rs2_addr    = r2;
            rs1_used    = u1;
            rs2_used    = u2;
            src_eval(r1, u1, s1, f1, d1);
            src_eval(r2, u2, s2, f2, d2);
            exp_stall = v && (s1 || s2);
            exp_f1    = v && f1;
            exp_f2    = v && f2;
            exp_f1d   = d1;
            exp_f2d   = d2;
            @(posedge clk);
            if (!v) begin
                done = 1'b1;
            end else if (!exp_stall) begin
                inflight.push_back('{cyc + 1, we, kind, rdv, val});
                if (we) sb.push_back('{cyc + int'(DEPTH), rdv, val});
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 2 * int'(DEPTH)) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_timeout: op rd=%0d still stalled after %0d cycles", rdv, waited);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) issue_op(1'b0, 1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n       = 1'b0;
        in_reset    = 1'b1;
        issue_valid = 1'b0;
        exp_stall   = 1'b0;
        exp_f1      = 1'b0;
        exp_f2      = 1'b0;
        inflight.delete();
        sb.delete();
        repeat (n) @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the model every cycle.
    always @(negedge clk) begin
        wb_t  w;
        logic exp_wb;
        #1;
        if (in_reset) begin
            chk("reset_wb_en", 32'(wb_en), 32'd0);
            chk("reset_stall", 32'(issue_stall), 32'd0);
            chk("reset_fwd1_en", 32'(fwd1_en), 32'd0);
            chk("reset_fwd2_en", 32'(fwd2_en), 32'd0);
        end else begin
            chk("issue_stall", 32'(issue_stall), 32'(exp_stall));
            chk("fwd1_en", 32'(fwd1_en), 32'(exp_f1));
            chk("fwd2_en", 32'(fwd2_en), 32'(exp_f2));
            if (exp_f1) chk("fwd1_data", fwd1_data, exp_f1d);
            if (exp_f2) chk("fwd2_data", fwd2_data, exp_f2d);
            exp_wb = (sb.size() > 0) && (sb[0].due == cyc);
            chk("wb_en", 32'(wb_en), 32'(exp_wb));
            if (exp_wb) begin
                w = sb.pop_front();
                if (wb_en) begin
                    chk("wb_rd", 32'(wb_rd), 32'(w.rd));
                    chk("wb_data", wb_data, w.val);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_kind  = 2'd0;
        issue_rd    = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        cvt_data    = '0;
        load_data   = '0;
        adsb_data   = '0;
        mul_data    = '0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        idle(2);

        // Single MUL writeback.
        issue_op(1'b1, 1'b1, 2'd3, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 32'h4040_0000);
        idle(7);
        // Back-to-back LOAD then ADSB, consecutive in-order writebacks.
        issue_op(1'b1, 1'b1, 2'd1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h3F80_0000);
        issue_op(1'b1, 1'b1, 2'd2, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 32'h4000_0000);
        idle(7);
        // RAW on rd=4 behind ADSB.
        issue_op(1'b1, 1'b1, 2'd2, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 32'h1111_2222);
        issue_op(1'b1, 1'b1, 2'd0, 5'd5, 5'd4, 5'd0, 1'b1, 1'b0, 32'h3333_4444);
        idle(7);
        // Non-writing op creates no hazard and no writeback.
        issue_op(1'b1, 1'b0, 2'd2, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 32'h5555_6666);
        issue_op(1'b1, 1'b1, 2'd0, 5'd7, 5'd4, 5'd0, 1'b1, 1'b0, 32'h7777_8888);
        idle(7);
        // Reset with three ops in flight.
        issue_op(1'b1, 1'b1, 2'd3, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 32'hAAAA_0001);
        issue_op(1'b1, 1'b1, 2'd2, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 32'hAAAA_0002);
        issue_op(1'b1, 1'b1, 2'd1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 32'hAAAA_0003);
        do_reset(1);
        idle(7);
        // CVT then dependent op two cycles later; same with MUL.
        issue_op(1'b1, 1'b1, 2'd0, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 32'h4120_0000);
        idle(1);
        issue_op(1'b1, 1'b1, 2'd2, 5'd11, 5'd0, 5'd6, 1'b0, 1'b1, 32'h0BAD_F00D);
        idle(7);
        issue_op(1'b1, 1'b1, 2'd3, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 32'h4150_0000);
        idle(1);
        issue_op(1'b1, 1'b1, 2'd2, 5'd12, 5'd0, 5'd6, 1'b0, 1'b1, 32'h0C0F_FEE0);
        idle(7);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset(2);
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                issue_op(1'b1, ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
                         RAG_AW'($urandom_range(0, 7)), RAG_AW'($urandom_range(0, 7)),
                         RAG_AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), $urandom);
            end
        end
        idle(int'(DEPTH) + 3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
